imm_extend_unit: RTL and testbench

Parametrised, pipelined immediate-generation unit that turns narrow instruction immediate fields into full datapath-width operands. It supports sign-extend, zero-extend, sign-extend with left shift for branch offsets, and a two-beat concatenate mode for building full-width constants. It sits between instruction decode and the ALU-B / PC-offset operand muxes, with valid/ready handshakes on both sides.

---
 rtl/imm_extend_unit.sv | 176 +++++++++++++++++
 tb/tb_imm_extend_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_unit.sv
// Pipelined immediate generator: SEXT / ZEXT / SEXT_SHL / two-beat CONCAT with valid/ready on both sides.
// Optional macro IMM_EXTEND_SKID_EN adds a one-entry skid register so in_ready is registered.
module imm_extend_unit #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int SHL   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_hi_pending
);

  localparam logic [1:0] MODE_SEXT     = 2'b00;
  localparam logic [1:0] MODE_ZEXT     = 2'b01;
  localparam logic [1:0] MODE_SEXT_SHL = 2'b10;
  localparam logic [1:0] MODE_CONCAT   = 2'b11;

  typedef enum logic {IDLE = 1'b0, HI_HELD = 1'b1} state_t;

  function automatic logic [OUT_W-1:0] sext_f(input logic [IN_W-1:0] d);
    return {{(OUT_W-IN_W){d[IN_W-1]}}, d};
  endfunction

  function automatic logic [OUT_W-1:0] zext_f(input logic [IN_W-1:0] d);
    return {{(OUT_W-IN_W){1'b0}}, d};
  endfunction

  function automatic logic [OUT_W-1:0] concat_f(input logic [IN_W-1:0] hi, input logic [IN_W-1:0] lo);
    logic [OUT_W+IN_W-1:0] wide;
    wide = ({{OUT_W{1'b0}}, hi} << IN_W) | {{OUT_W{1'b0}}, lo};
    return wide[OUT_W-1:0];
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [IN_W-1:0]    hi_r;
  logic               out_valid_r;
  logic [OUT_W-1:0]   out_data_r;
  logic [OUT_W-1:0]   result_s;
  logic               accept_s;
  logic               consume_s;
  logic               produce_s;
  logic               in_ready_s;

  assign accept_s  = in_valid && in_ready_s;
  assign consume_s = out_valid_r && out_ready;
  // An upper CONCAT beat in IDLE is absorbed by the FSM and produces nothing.
  assign produce_s = accept_s && ((state_r == HI_HELD) || (in_mode != MODE_CONCAT));

  // Result datapath for the beat currently on the input.
  always_comb begin
    result_s = sext_f(in_data);
    if (state_r == HI_HELD) begin
      result_s = concat_f(hi_r, in_data);
    end else begin
      case (in_mode)
        MODE_SEXT:     result_s = sext_f(in_data);
        MODE_ZEXT:     result_s = zext_f(in_data);
        MODE_SEXT_SHL: result_s = sext_f(in_data) << SHL;
        default:       result_s = sext_f(in_data);
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (flush) begin
      state_nxt_s = IDLE;
    end else if (accept_s) begin
      case (state_r)
        IDLE:    state_nxt_s = (in_mode == MODE_CONCAT) ? HI_HELD : IDLE;
        HI_HELD: state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM output decode.
  always_comb begin
    out_hi_pending = 1'b0;
    if (state_r == HI_HELD) begin
      out_hi_pending = 1'b1;
    end else begin
      out_hi_pending = 1'b0;
    end
  end

  // Upper CONCAT half capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= {IN_W{1'b0}};
    end else if (!flush && accept_s && (state_r == IDLE) && (in_mode == MODE_CONCAT)) begin
      hi_r <= in_data;
    end else begin
      hi_r <= hi_r;
    end
  end

`ifdef IMM_EXTEND_SKID_EN
  logic             skid_valid_r;
  logic [OUT_W-1:0] skid_data_r;

  // in_ready comes straight from the skid flop, so out_ready never reaches it combinationally.
  assign in_ready_s = !skid_valid_r;

  // Output register plus skid entry; a result accepted during a stall parks in the skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= {OUT_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {OUT_W{1'b0}};
    end else if (flush) begin
      out_valid_r  <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (produce_s && (!out_valid_r || consume_s)) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
    end else if (produce_s) begin
      skid_valid_r <= 1'b1;
      skid_data_r  <= result_s;
    end else if (consume_s && skid_valid_r) begin
      out_data_r   <= skid_data_r;
      skid_valid_r <= 1'b0;
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end
`else
  assign in_ready_s = !out_valid_r || out_ready;

  // Single output register; a new result may replace the one consumed this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {OUT_W{1'b0}};
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (produce_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= result_s;
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end
`endif

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: directed scenarios plus randomized traffic vs a queue-based model.
module tb_imm_extend_unit;
  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int SHL   = 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_hi_pending;

  imm_extend_unit #(.IN_W(IN_W), .OUT_W(OUT_W), .SHL(SHL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_hi_pending(out_hi_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: results in acceptance order, plus the pending upper half.
  int q_exp[$];
  bit hi_pend = 1'b0;
  int hi_val  = 0;

`ifdef IMM_EXTEND_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_result(input int mode, input int d);
    int s;
    int mask;
    mask = (1 << OUT_W) - 1;
    s = (d >= (1 << (IN_W - 1))) ? d - (1 << IN_W) : d;
    case (mode)
      0:       return s & mask;
      1:       return d & mask;
      2:       return (s * (1 << SHL)) & mask;
      default: return s & mask;
    endcase
  endfunction

  // One clock: drive, check at negedge against the model, advance model, return #1 after posedge.
  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] m, input logic ordy, input logic fl);
    bit exp_ready;
    bit consume;
    int exp_val;
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy; flush = fl;
    @(negedge clk);
    if (SKID) exp_ready = (q_exp.size() < 2);
    else      exp_ready = (q_exp.size() == 0) || ordy;
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, (q_exp.size() != 0)});
    check_eq("hi_pending", {31'd0, out_hi_pending}, {31'd0, hi_pend});
    consume = (q_exp.size() != 0) && ordy;
    if (fl) begin
      q_exp.delete();
      hi_pend = 1'b0;
    end else begin
      if (consume) begin
        exp_val = q_exp.pop_front();
        check_eq("out_data", {16'd0, out_data}, exp_val);
      end
      if (v && exp_ready) begin
        if (hi_pend) begin
          q_exp.push_back((hi_val * (1 << IN_W) + int'(d)) & ((1 << OUT_W) - 1));
          hi_pend = 1'b0;
        end else if (m == 2'b11) begin
          hi_pend = 1'b1;
          hi_val  = int'(d);
        end else begin
          q_exp.push_back(ref_result(int'(m), int'(d)));
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_mode = 2'b00;
    out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_out_data", {16'd0, out_data}, 32'd0);
    check_eq("rst_hi_pending", {31'd0, out_hi_pending}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic extension modes.
    step(1'b1, 8'h80, 2'b00, 1'b1, 1'b0);
    check_eq("sext80", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'hFF80});
    step(1'b1, 8'h80, 2'b01, 1'b1, 1'b0);
    check_eq("zext80", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h0080});
    step(1'b1, 8'hFE, 2'b10, 1'b1, 1'b0);
    check_eq("shlFE", {16'd0, out_data}, 32'h0000FFFC);
    step(1'b1, 8'h7F, 2'b10, 1'b1, 1'b0);
    check_eq("shl7F", {16'd0, out_data}, 32'h000000FE);

    // CONCAT pair.
    step(1'b1, 8'h12, 2'b11, 1'b1, 1'b0);
    check_eq("cat_pending", {30'd0, out_hi_pending, out_valid}, 32'd2);
    step(1'b1, 8'h34, 2'b00, 1'b1, 1'b0);
    check_eq("cat_result", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h1234});
    check_eq("cat_pend_clr", {31'd0, out_hi_pending}, 32'd0);
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    check_eq("cat_single", {31'd0, out_valid}, 32'd0);

    // Backpressure: result held, second beat waits (or parks in skid).
    step(1'b1, 8'h05, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h06, 2'b01, 1'b0, 1'b0);
      check_eq("stall_hold", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h0005});
      check_eq("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    step(1'b1, 8'h06, 2'b01, 1'b1, 1'b0);
    check_eq("release_next", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h0006});
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    check_eq("drain_empty", {31'd0, out_valid}, 32'd0);

    // Flush drops a held upper half.
    step(1'b1, 8'h12, 2'b11, 1'b1, 1'b0);
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b1);
    check_eq("flush_pend", {31'd0, out_hi_pending}, 32'd0);
    step(1'b1, 8'h01, 2'b00, 1'b1, 1'b0);
    check_eq("flush_sext", {15'd0, out_valid, out_data}, {15'd0, 1'b1, 16'h0001});
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);

    // Reset mid-operation.
    step(1'b1, 8'hAB, 2'b01, 1'b1, 1'b0);
    step(1'b1, 8'h55, 2'b11, SKID ? 1'b0 : 1'b1, 1'b0);
    check_eq("pre_rst_pend", {31'd0, out_hi_pending}, 32'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("arst_state", {14'd0, out_valid, out_hi_pending, out_data}, 32'd0);
    q_exp.delete();
    hi_pend = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("arst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    step(1'b1, 8'h01, 2'b00, 1'b1, 1'b0);
    check_eq("post_rst_sext", {16'd0, out_data}, 32'h00000001);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
    end
    check_eq("final_queue", q_exp.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
